// File: rtl/shift_unit_arbiter.sv
// shift_unit_arbiter
// Shares one external 32-bit combinational logical right shifter between two
// requesters (ALU shift path on port 0, load/store alignment on port 1).
// SRL, SLL, SRA and ROR are all built from right-shift passes through that
// shifter. One operation is in flight at a time, and the result comes back
// registered and tagged with the id of the requester that issued it.

module shift_unit_arbiter #(
  parameter int W    = 32,
  parameter int NREQ = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,

  input  logic                      req0_valid,
  output logic                      req0_ready,
  input  logic [1:0]                req0_op,
  input  logic [W-1:0]              req0_a,
  input  logic [W-1:0]              req0_b,

  input  logic                      req1_valid,
  output logic                      req1_ready,
  input  logic [1:0]                req1_op,
  input  logic [W-1:0]              req1_a,
  input  logic [W-1:0]              req1_b,

  output logic [W-1:0]              sh_a,
  output logic [W-1:0]              sh_b,
  input  logic [W-1:0]              sh_s,

  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [W-1:0]              rsp_data
);

  localparam int         IDW     = $clog2(NREQ);
  localparam int         AMTW    = $clog2(W);
  localparam logic [W-1:0] WIDTH_V = W;

  localparam logic [1:0] OP_SRL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    EXEC2 = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;

  // rr_ptr names the requester preferred when both are valid
  logic             rr_ptr;
  logic             grant0;
  logic             grant1;
  logic             handshake;

  logic [1:0]       op_r;
  logic [W-1:0]     a_r;
  logic [W-1:0]     b_r;
  logic [IDW-1:0]   id_r;
  logic [W-1:0]     tmp_r;

  logic [AMTW-1:0]  amt;
  logic [W-1:0]     amt_ext;
  logic             ror_pending;
  logic [W-1:0]     sra_keep;
  logic [W-1:0]     p1;

  logic             rsp_load;
  logic             tmp_load;
  logic [W-1:0]     rsp_nxt;

  function automatic logic [W-1:0] bitrev(input logic [W-1:0] x);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) begin
      r[i] = x[W-1-i];
    end
    return r;
  endfunction

  // Round-robin choice between the two requesters
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      grant0 = ~rr_ptr;
      grant1 = rr_ptr;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  // Ready is only offered while idle and out of reset, so the handshake
  // never fires during reset or while an operation is in flight
  assign req0_ready = rst_n & (state == IDLE) & grant0;
  assign req1_ready = rst_n & (state == IDLE) & grant1;
  assign handshake  = req0_ready | req1_ready;

  // ROR only needs the low amount bits; a zero rotate finishes in one pass
  assign amt         = b_r[AMTW-1:0];
  assign amt_ext     = {{(W-AMTW){1'b0}}, amt};
  assign ror_pending = (op_r == OP_ROR) && (amt != '0);

  // Bits kept from a logical right shift; the rest are filled for SRA
  assign sra_keep = (b_r >= WIDTH_V) ? '0 : ({W{1'b1}} >> b_r);

  // Shifter inputs: driven only in the execute states, zero otherwise
  always_comb begin
    sh_a = '0;
    sh_b = '0;
    case (state)
      EXEC: begin
        sh_a = (op_r == OP_SLL) ? bitrev(a_r) : a_r;
        sh_b = (op_r == OP_ROR) ? amt_ext : b_r;
      end
      EXEC2: begin
        sh_a = bitrev(a_r);
        sh_b = WIDTH_V - amt_ext;
      end
      default: begin
      end
    endcase
  end

  // First-pass post-processing of the shifter result
  always_comb begin
    p1 = sh_s;
    case (op_r)
      OP_SLL: p1 = bitrev(sh_s);
      OP_SRA: begin
        if (a_r[W-1]) begin
          p1 = sh_s | ~sra_keep;
        end
      end
      default: begin
      end
    endcase
  end

  // Next-state logic and result load strobes
  always_comb begin
    state_nxt = state;
    rsp_load  = 1'b0;
    tmp_load  = 1'b0;
    rsp_nxt   = p1;
    case (state)
      IDLE: begin
        if (handshake) begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (ror_pending) begin
          tmp_load  = 1'b1;
          state_nxt = EXEC2;
        end else begin
          rsp_load  = 1'b1;
          state_nxt = RESP;
        end
      end
      EXEC2: begin
        rsp_load  = 1'b1;
        rsp_nxt   = tmp_r | bitrev(sh_s);
        state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture the granted request; later operand changes are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r   <= OP_SRL;
      a_r    <= '0;
      b_r    <= '0;
      id_r   <= '0;
      rr_ptr <= 1'b0;
    end else if (handshake) begin
      op_r   <= req1_ready ? req1_op : req0_op;
      a_r    <= req1_ready ? req1_a  : req0_a;
      b_r    <= req1_ready ? req1_b  : req0_b;
      id_r   <= req1_ready;
      rr_ptr <= req0_ready;
    end
  end

  // Hold the ROR first pass and present the registered response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmp_r     <= '0;
      rsp_data  <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
    end else begin
      if (tmp_load) begin
        tmp_r <= p1;
      end
      if (rsp_load) begin
        rsp_data  <= rsp_nxt;
        rsp_valid <= 1'b1;
        rsp_id    <= id_r;
      end else if ((state == RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule
